keypad_matrix_scanner: RTL

- Scans a 4x4 push-button matrix and reports debounced key presses to the controller.
- Drives one active-low column strobe per scan step and samples four pulled-up, active-low row inputs.
- Debounces whole-matrix frames and emits one key code per press through a valid/ack handshake.
- Input-side counterpart of the column-scanned LED matrix driver; uses the same CE scan tick.

---
 rtl/keypad_matrix_scanner.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: column strobing, row synchronisation, whole-frame debounce,
// anti-ghosting press-event FSM and a valid/ack key report with sticky overflow.
module keypad_matrix_scanner #(
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CE,
    input  logic [3:0] rows_in,
    output logic [3:0] col_select,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_held,
    output logic       multi_key,
    output logic       overflow
);
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned FRAME_W  = NUM_ROWS * NUM_COLS;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned POP_W    = 5;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_MULTI
    } state_t;

    logic [NUM_ROWS-1:0] sync1_q, sync1_d;
    logic [NUM_ROWS-1:0] sync2_q, sync2_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
    logic [FRAME_W-1:0]  raw_q, raw_d;
    logic                frame_end_q, frame_end_d;
    logic [FRAME_W-1:0]  prev_q, prev_d;
    logic [FRAME_W-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                upd_q, upd_d;
    state_t              state_q, state_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;
    logic                multi_key_q, multi_key_d;
    logic                overflow_q, overflow_d;

    logic [FRAME_W-1:0]  pressed;
    logic [POP_W-1:0]    n_pressed;
    logic [3:0]          key_idx;
    logic                press_ev;

    // Scan: frames are stored active-low as sampled; one column per CE.
    always_comb begin
        sync1_d     = rows_in;
        sync2_d     = sync1_q;
        col_d       = col_q;
        raw_d       = raw_q;
        frame_end_d = 1'b0;
        if (CE) begin
            raw_d[{col_q, 2'b00} +: NUM_ROWS] = sync2_q;
            col_d       = col_q + 2'd1;
            frame_end_d = (col_q == 2'd3);
        end
        col_sel_d = ~(4'b0001 << col_d);
    end

    // Debounce: stable follows the raw frame after DEBOUNCE_FRAMES identical frames.
    always_comb begin
        prev_d   = prev_q;
        count_d  = count_q;
        stable_d = stable_q;
        upd_d    = 1'b0;
        if (frame_end_q) begin
            if (raw_q == prev_q) begin
                count_d = (count_q >= DEB_MAX) ? DEB_MAX : count_q + CNT_W'(1);
            end else begin
                count_d = CNT_W'(1);
            end
            prev_d = raw_q;
            if ((count_d == DEB_MAX) && (raw_q != stable_q)) begin
                stable_d = raw_q;
                upd_d    = 1'b1;
            end
        end
    end

    // Count pressed keys in the stable frame; key_idx is the code when exactly one.
    always_comb begin
        pressed   = ~stable_q;
        n_pressed = '0;
        key_idx   = '0;
        for (int i = 0; i < int'(FRAME_W); i++) begin
            if (pressed[i]) begin
                n_pressed = n_pressed + POP_W'(1);
                key_idx   = 4'(i);
            end
        end
    end

    // Event FSM and handshake; a changed stable frame is the only trigger.
    always_comb begin
        state_d     = state_q;
        press_ev    = 1'b0;
        key_code_d  = key_code_q;
        key_valid_d = key_valid_q;
        overflow_d  = overflow_q;
        if (upd_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (n_pressed == POP_W'(1)) begin
                        state_d  = ST_PRESSED;
                        press_ev = 1'b1;
                    end else if (n_pressed >= POP_W'(2)) begin
                        state_d = ST_MULTI;
                    end
                end
                ST_PRESSED: begin
                    if (n_pressed == '0) begin
                        state_d = ST_IDLE;
                    end else if (n_pressed >= POP_W'(2)) begin
                        state_d = ST_MULTI;
                    end else begin
                        press_ev = 1'b1;
                    end
                end
                ST_MULTI: begin
                    if (n_pressed == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (press_ev) begin
            if (!key_valid_q || key_ack) begin
                key_code_d  = key_idx;
                key_valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (key_valid_q && key_ack) begin
            key_valid_d = 1'b0;
        end

        key_held_d  = (state_d == ST_PRESSED);
        multi_key_d = (state_d == ST_MULTI);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            col_q       <= 2'd0;
            col_sel_q   <= 4'b1110;
            raw_q       <= '1;
            frame_end_q <= 1'b0;
            prev_q      <= '1;
            stable_q    <= '1;
            count_q     <= '0;
            upd_q       <= 1'b0;
            state_q     <= ST_IDLE;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            col_q       <= col_d;
            col_sel_q   <= col_sel_d;
            raw_q       <= raw_d;
            frame_end_q <= frame_end_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            count_q     <= count_d;
            upd_q       <= upd_d;
            state_q     <= state_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
            multi_key_q <= multi_key_d;
            overflow_q  <= overflow_d;
        end
    end

    assign col_select = col_sel_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign key_held   = key_held_q;
    assign multi_key  = multi_key_q;
    assign overflow   = overflow_q;

endmodule
